// File: rtl/mem_port_arbiter_if.sv
// Bundle of both masters' request ports and the memory-side port.
// The arbiter takes the slave view; masters and memory take the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              owner;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  mem_rdata,
        output ack0, ack1, rdata0, rdata1,
        output mem_addr, mem_wdata, mem_we, busy, owner
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output mem_rdata,
        input  ack0, ack1, rdata0, rdata1,
        input  mem_addr, mem_wdata, mem_we, busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin two-master arbiter and sequencer for a single-port data memory.
// Each access runs ISSUE, WAIT (MEM_LAT edges), ACK, then returns to IDLE.
module mem_port_arbiter #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input logic               clock,
    input logic               resetn,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;
    logic              mwe_q, mwe_d;
    logic              gnt;

    // On a tie the port that did not win last time is granted.
    assign gnt = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

    // Next-state and output-register logic for the access sequence.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        mwe_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    owner_d  = gnt;
                    last_d   = gnt;
                    we_d     = gnt ? bus.we1 : bus.we0;
                    mwe_d    = gnt ? bus.we1 : bus.we0;
                    maddr_d  = gnt ? bus.addr1 : bus.addr0;
                    mwdata_d = gnt ? bus.wdata1 : bus.wdata0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = LAT_M1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    if (!we_q) begin
                        if (owner_q) rdata1_d = bus.mem_rdata;
                        else         rdata0_d = bus.mem_rdata;
                    end
                    ack0_d  = ~owner_q;
                    ack1_d  = owner_q;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ACK: begin
                maddr_d  = '0;
                mwdata_d = '0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset abandons any access in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            cnt_q    <= 3'd0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mwe_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            mwe_q    <= mwe_d;
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wdata = mwdata_q;
    assign bus.mem_we    = mwe_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1 with a
// memory model, one at MEM_LAT=3 with a hand-driven read bus.
module tb_mem_port_arbiter;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    logic [15:0] mem [0:127];
    int          ack_port [$];
    int          ack_cyc [$];

    mem_port_arbiter_if #(.ADDR_W(7), .DATA_W(16)) ia ();
    mem_port_arbiter_if #(.ADDR_W(7), .DATA_W(16)) ib ();

    mem_port_arbiter #(.ADDR_W(7), .DATA_W(16), .MEM_LAT(1)) dut_a (
        .clock (clock),
        .resetn(resetn),
        .bus   (ia.slave)
    );

    mem_port_arbiter #(.ADDR_W(7), .DATA_W(16), .MEM_LAT(3)) dut_b (
        .clock (clock),
        .resetn(resetn),
        .bus   (ib.slave)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    assign ia.mem_rdata = mem[ia.mem_addr];
    always @(posedge clock) if (ia.mem_we) mem[ia.mem_addr] <= ia.mem_wdata;

    always @(negedge clock) begin
        if (ia.ack0) begin ack_port.push_back(0); ack_cyc.push_back(cyc); end
        if (ia.ack1) begin ack_port.push_back(1); ack_cyc.push_back(cyc); end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step(2);
        resetn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'(i);
        mem[5] = 16'h1234;
        {ia.req0, ia.req1, ia.we0, ia.we1} = '0;
        {ia.addr0, ia.addr1, ia.wdata0, ia.wdata1} = '0;
        {ib.req0, ib.req1, ib.we0, ib.we1} = '0;
        {ib.addr0, ib.addr1, ib.wdata0, ib.wdata1} = '0;
        ib.mem_rdata = 16'h0;

        // reset values
        step(1);
        chk("rst_busy", ia.busy, 0);
        chk("rst_owner", ia.owner, 0);
        chk("rst_acks", {ia.ack0, ia.ack1}, 0);
        chk("rst_memwe", ia.mem_we, 0);
        chk("rst_rdata0", ia.rdata0, 0);
        do_reset();

        // single read of addr 5 on port 0
        ia.req0 = 1; ia.we0 = 0; ia.addr0 = 7'd5;
        step(1);
        ia.req0 = 0;
        chk("rd_addr", ia.mem_addr, 5);
        chk("rd_busy", ia.busy, 1);
        chk("rd_owner", ia.owner, 0);
        chk("rd_we", ia.mem_we, 0);
        step(1);
        chk("rd_ack_early", ia.ack0, 0);
        step(1);
        chk("rd_ack0", ia.ack0, 1);
        chk("rd_ack1", ia.ack1, 0);
        chk("rd_data", ia.rdata0, 16'h1234);
        step(1);
        chk("rd_ack_drop", ia.ack0, 0);
        chk("rd_idle", ia.busy, 0);
        chk("rd_addr_clr", ia.mem_addr, 0);
        chk("rd_hold", ia.rdata0, 16'h1234);

        // write 0xBEEF to addr 3 on port 1
        ia.req1 = 1; ia.we1 = 1; ia.addr1 = 7'd3; ia.wdata1 = 16'hBEEF;
        step(1);
        ia.req1 = 0;
        chk("wr_we", ia.mem_we, 1);
        chk("wr_addr", ia.mem_addr, 3);
        chk("wr_data", ia.mem_wdata, 16'hBEEF);
        chk("wr_owner", ia.owner, 1);
        step(1);
        chk("wr_we_drop", ia.mem_we, 0);
        chk("wr_data_hold", ia.mem_wdata, 16'hBEEF);
        step(1);
        chk("wr_ack1", ia.ack1, 1);
        chk("wr_ack0", ia.ack0, 0);
        chk("wr_rdata1", ia.rdata1, 0);
        step(1);

        // read back addr 3 on port 0
        ia.req0 = 1; ia.we0 = 0; ia.addr0 = 7'd3;
        step(1);
        ia.req0 = 0;
        step(2);
        chk("rb_ack0", ia.ack0, 1);
        chk("rb_data", ia.rdata0, 16'hBEEF);
        chk("rb_rdata1", ia.rdata1, 0);
        step(1);

        // tie after reset, then continuous contention for 8 accesses
        do_reset();
        ack_port.delete();
        ack_cyc.delete();
        ia.req0 = 1; ia.we0 = 0; ia.addr0 = 7'd10;
        ia.req1 = 1; ia.we1 = 0; ia.addr1 = 7'd11;
        step(1);
        chk("tie_owner", ia.owner, 0);
        chk("tie_addr", ia.mem_addr, 10);
        for (int n = 0; n < 100 && ack_port.size() < 8; n++) step(1);
        ia.req0 = 0; ia.req1 = 0;
        chk("cont_count", ack_port.size(), 8);
        for (int i = 0; i < ack_port.size(); i++) begin
            chk($sformatf("cont_port%0d", i), ack_port[i], i % 2);
            if (i > 0)
                chk($sformatf("cont_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 4);
        end
        chk("cont_rdata0", ia.rdata0, 16'd10);
        chk("cont_rdata1", ia.rdata1, 16'd11);
        step(3);

        // MEM_LAT=3 read on the second instance
        ib.req0 = 1; ib.we0 = 0; ib.addr0 = 7'd20;
        step(1);
        ib.req0 = 0;
        chk("l3_addr", ib.mem_addr, 20);
        ib.mem_rdata = 16'h1001;
        step(1);
        ib.mem_rdata = 16'h1002;
        step(1);
        ib.mem_rdata = 16'h1003;
        step(1);
        chk("l3_ack_early", ib.ack0, 0);
        ib.mem_rdata = 16'h1004;
        step(1);
        ib.mem_rdata = 16'h1005;
        chk("l3_ack", ib.ack0, 1);
        chk("l3_data", ib.rdata0, 16'h1004);
        step(1);
        chk("l3_ack_drop", ib.ack0, 0);
        chk("l3_hold", ib.rdata0, 16'h1004);

        // reset in the middle of a write's WAIT phase
        ack_port.delete();
        ack_cyc.delete();
        ia.req0 = 1; ia.we0 = 1; ia.addr0 = 7'd9; ia.wdata0 = 16'h5555;
        step(1);
        chk("mr_we", ia.mem_we, 1);
        step(1);
        chk("mr_wait_busy", ia.busy, 1);
        resetn = 1'b0;
        #1;
        chk("mr_busy", ia.busy, 0);
        chk("mr_addr", ia.mem_addr, 0);
        chk("mr_we0", ia.mem_we, 0);
        step(2);
        chk("mr_noack", ack_port.size(), 0);
        mem[9] = 16'h0;
        resetn = 1'b1;
        step(1);
        chk("mr2_busy", ia.busy, 1);
        chk("mr2_we", ia.mem_we, 1);
        chk("mr2_addr", ia.mem_addr, 9);
        ia.req0 = 0;
        step(2);
        chk("mr2_ack", ia.ack0, 1);
        chk("mr2_mem", mem[9], 16'h5555);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
